// File: rtl/lifo_stack_ext.sv
// lifo_stack_ext: parametrised LIFO stack with occupancy count, combinational
// top-of-stack peek, almost-full threshold, sticky overflow/underflow flags,
// synchronous clear and replace-top on simultaneous push+pop.
// Optional feature macro: LIFO_STACK_HWM_EN adds the hwm_o high-water-mark output.
module lifo_stack_ext #(
    parameter int WIDTH    = 8,
    parameter int LENGTH   = 5,
    parameter int AF_LEVEL = 4,
    localparam int CW      = $clog2(LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] top_o,
    output logic [CW-1:0]    count_o,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow,
`ifdef LIFO_STACK_HWM_EN
    output logic             underflow,
    output logic [CW-1:0]    hwm_o
`else
    output logic             underflow
`endif
);

    localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic [WIDTH-1:0] mem [LENGTH];

    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_word;
    logic [LENGTH-1:0] entry_we;

    // Stack pointer equals count; the top entry lives one slot below it.
    assign top_idx  = AW'(count_reg - CW'(1));
    assign top_word = mem[top_idx];

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CW'(LENGTH));
    assign almost_full = (count_reg >= CW'(AF_LEVEL));
    assign count_o     = count_reg;
    assign top_o       = empty ? '0 : top_word;
    assign data_o      = data_reg;
    assign valid_o     = valid_reg;
    assign overflow    = ovf_reg;
    assign underflow   = udf_reg;

    // Next-state decode: clear wins, then the push/pop combination.
    always_comb begin
        count_next = count_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ovf_next   = ovf_reg;
        udf_next   = udf_reg;
        wr_en      = 1'b0;
        wr_idx     = AW'(count_reg);
        if (clear_i) begin
            count_next = '0;
            ovf_next   = 1'b0;
            udf_next   = 1'b0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (!full) begin
                        wr_en      = 1'b1;
                        count_next = count_reg + CW'(1);
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        data_next  = top_word;
                        valid_next = 1'b1;
                        count_next = count_reg - CW'(1);
                    end else begin
                        udf_next = 1'b1;
                    end
                end
                2'b11: begin
                    valid_next = 1'b1;
                    if (!empty) begin
                        // Replace-top: emit the old top, overwrite it in place.
                        data_next = top_word;
                        wr_en     = 1'b1;
                        wr_idx    = top_idx;
                    end else begin
                        // Nothing stored: the pushed word passes straight through.
                        data_next = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-entry write enables decoded from the single write port.
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_entry_we
        assign entry_we[gi] = wr_en && (wr_idx == AW'(gi));
    end

    // Storage array; contents are not reset, only the pointer is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LENGTH; i++) begin
            if (entry_we[i]) mem[i] <= data_i;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

`ifdef LIFO_STACK_HWM_EN
    logic [CW-1:0] hwm_reg, hwm_next;

    // High-water mark tracks the largest count reached since reset or clear.
    always_comb begin
        hwm_next = hwm_reg;
        if (clear_i) hwm_next = '0;
        else if (count_next > hwm_reg) hwm_next = count_next;
    end

    // High-water-mark register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) hwm_reg <= '0;
        else       hwm_reg <= hwm_next;
    end

    assign hwm_o = hwm_reg;
`endif

endmodule

// File: tb/tb_lifo_stack_ext.sv
// tb_lifo_stack_ext: directed test of lifo_stack_ext against a queue-based model,
// plus literal expectations at the key points of each scenario.
module tb_lifo_stack_ext;

    localparam int WIDTH    = 8;
    localparam int LENGTH   = 5;
    localparam int AF_LEVEL = 4;
    localparam int CW       = $clog2(LENGTH + 1);

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             clear_i = 1'b0;
    logic             push_i = 1'b0;
    logic             pop_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic [WIDTH-1:0] top_o;
    logic [CW-1:0]    count_o;
    logic             full, empty, almost_full, overflow, underflow;
`ifdef LIFO_STACK_HWM_EN
    logic [CW-1:0]    hwm_o;
`endif

    lifo_stack_ext #(.WIDTH(WIDTH), .LENGTH(LENGTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear_i), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .data_o(data_o), .valid_o(valid_o), .top_o(top_o),
        .count_o(count_o), .full(full), .empty(empty), .almost_full(almost_full),
`ifdef LIFO_STACK_HWM_EN
        .overflow(overflow), .underflow(underflow), .hwm_o(hwm_o)
`else
        .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: a plain queue plus the registered outputs.
    int m_stk[$];
    int m_data, m_valid, m_ovf, m_udf, m_hwm;
    bit cmp_pending = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_stk.delete();
        m_data = 0; m_valid = 0; m_ovf = 0; m_udf = 0; m_hwm = 0;
    endfunction

    function automatic void model_step(input bit clr, input bit push, input bit pop,
                                       input int d);
        m_valid = 0;
        if (clr) begin
            m_stk.delete();
            m_ovf = 0; m_udf = 0; m_hwm = 0;
        end else if (push && !pop) begin
            if (m_stk.size() < LENGTH) m_stk.push_back(d);
            else m_ovf = 1;
        end else if (pop && !push) begin
            if (m_stk.size() > 0) begin m_data = m_stk.pop_back(); m_valid = 1; end
            else m_udf = 1;
        end else if (push && pop) begin
            m_valid = 1;
            if (m_stk.size() > 0) begin m_data = m_stk.pop_back(); m_stk.push_back(d); end
            else m_data = d;
        end
        if (m_stk.size() > m_hwm) m_hwm = m_stk.size();
    endfunction

    // Compare process: checks every output after each modelled clock edge.
    always @(negedge clk) begin
        if (cmp_pending) begin
            int sz;
            cmp_pending = 1'b0;
            sz = m_stk.size();
            chk("count_o", int'(count_o), sz);
            chk("data_o", int'(data_o), m_data);
            chk("valid_o", int'(valid_o), m_valid);
            chk("top_o", int'(top_o), (sz > 0) ? m_stk[sz-1] : 0);
            chk("full", int'(full), int'(sz == LENGTH));
            chk("empty", int'(empty), int'(sz == 0));
            chk("almost_full", int'(almost_full), int'(sz >= AF_LEVEL));
            chk("overflow", int'(overflow), m_ovf);
            chk("underflow", int'(underflow), m_udf);
`ifdef LIFO_STACK_HWM_EN
            chk("hwm_o", int'(hwm_o), m_hwm);
`endif
        end
    end

    // One clocked transaction: drive at negedge, model at posedge, return at negedge.
    task automatic step(input bit clr, input bit push, input bit pop, input int d);
        clear_i = clr; push_i = push; pop_i = pop; data_i = WIDTH'(d);
        @(posedge clk);
        model_step(clr, push, pop, d);
        cmp_pending = 1'b1;
        $display("txn t=%0t clr=%0b push=%0b pop=%0b din=%02h -> model count=%0d data=%02h valid=%0d",
                 $time, clr, push, pop, d[7:0], m_stk.size(), m_data[7:0], m_valid);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        // Reset state, checked literally while reset is still held.
        chk("rst_count", int'(count_o), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_top", int'(top_o), 0);
        chk("rst_data", int'(data_o), 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: push 'a'..'p' into a 5-deep stack.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h61 + i);
        chk("t1_top_e", int'(top_o), 8'h65);
        chk("t1_count5", int'(count_o), 5);
        chk("t1_overflow", int'(overflow), 1);

        // 2: pop 20 times, underflow once empty.
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        chk("t2_data_a", int'(data_o), 8'h61);
        chk("t2_underflow", int'(underflow), 1);
        chk("t2_empty", int'(empty), 1);

        // 3: clear flags, then push+pop on empty stack bypasses.
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 8'h61 + i);
        chk("t3_data_p", int'(data_o), 8'h70);
        chk("t3_count0", int'(count_o), 0);
        chk("t3_no_ovf", int'(overflow), 0);
        chk("t3_no_udf", int'(underflow), 0);

        // 4: replace-top.
        step(0, 1, 0, 8'h78);
        step(0, 1, 0, 8'h79);
        step(0, 1, 1, 8'h7a);
        chk("t4_data_y", int'(data_o), 8'h79);
        chk("t4_top_z", int'(top_o), 8'h7a);
        chk("t4_count2", int'(count_o), 2);
        step(0, 0, 1, 0);
        chk("t4_pop_z", int'(data_o), 8'h7a);
        step(0, 0, 1, 0);
        chk("t4_pop_x", int'(data_o), 8'h78);

        // 6: high-water mark.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h30 + i);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 8'h40);
`ifdef LIFO_STACK_HWM_EN
        chk("t6_hwm3", int'(hwm_o), 3);
`endif
        step(1, 0, 0, 0);
`ifdef LIFO_STACK_HWM_EN
        chk("t6_hwm0", int'(hwm_o), 0);
`endif

        // 5: fill, clear with push held, then async reset mid-burst.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h90 + i);
        chk("t5_full", int'(full), 1);
        step(1, 1, 0, 8'haa);
        chk("t5_clr_count", int'(count_o), 0);
        chk("t5_clr_empty", int'(empty), 1);
        step(0, 1, 0, 8'hb0);
        step(0, 1, 0, 8'hb1);
        step(0, 0, 1, 0);
        push_i = 1'b1; pop_i = 1'b0; data_i = 8'hb2;
        #2 rstn = 1'b0;
        #1;
        chk("t5_arst_count", int'(count_o), 0);
        chk("t5_arst_data", int'(data_o), 0);
        chk("t5_arst_valid", int'(valid_o), 0);
        chk("t5_arst_top", int'(top_o), 0);
        chk("t5_arst_empty", int'(empty), 1);
        model_reset();
        cmp_pending = 1'b1;
        repeat (2) @(negedge clk);
        push_i = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        cmp_pending = 1'b1;
        @(negedge clk);
        step(0, 1, 0, 8'hc0);
        chk("t5_after_rst_top", int'(top_o), 8'hc0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
